// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with program counter and word-addressed instruction memory
//
// Optional feature macro: FETCH_ICOUNT_EN (defined: icount counts issued
// instructions and wraps at 2^32; undefined: no counter, icount tied to 0).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   prog_we    in   instruction memory write strobe, honoured only in IDLE
//   prog_addr  in   instruction memory write address
//   prog_data  in   instruction memory write data
//   start      in   one-cycle pulse, starts execution at PC 0 from IDLE
//   PCnew      in   decoder redirect target, 0 = no redirect
//   PC         out  address of the current or next instruction
//   ins        out  instruction word, BUBBLE_WORD when nothing is issued
//   ins_valid  out  high for the single cycle ins carries a real instruction
//   halted     out  sticky, execution finished
//   oob        out  sticky, halt caused by PC >= IMEM_DEPTH
//   icount     out  number of instructions issued
module fetch_unit #(
  parameter int unsigned IMEM_DEPTH  = 32,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter logic [31:0] BUBBLE_WORD = 32'hFC00_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          start,
  input  logic [31:0]                   PCnew,
  output logic [31:0]                   PC,
  output logic [31:0]                   ins,
  output logic                          ins_valid,
  output logic                          halted,
  output logic                          oob,
  output logic [31:0]                   icount
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_RESOLVE,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic        in_bounds;
  logic        issue;

  // Low address bits are only meaningful once in_bounds holds.
  assign in_bounds  = (PC < 32'(IMEM_DEPTH));
  assign fetch_word = mem[PC[AW-1:0]];
  assign issue      = (state == S_FETCH) && in_bounds && (fetch_word != HALT_WORD);

  // Memory has no reset so a program survives rst and can be rerun.
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      PC        <= '0;
      ins       <= BUBBLE_WORD;
      ins_valid <= 1'b0;
      halted    <= 1'b0;
      oob       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            PC    <= '0;
          end
        end
        S_FETCH: begin
          if (!in_bounds) begin
            state  <= S_HALT;
            halted <= 1'b1;
            oob    <= 1'b1;
          end else if (fetch_word == HALT_WORD) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            ins       <= fetch_word;
            ins_valid <= 1'b1;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Decoder consumes the word on this edge; bubble afterwards so it
          // never sees the same instruction twice.
          ins       <= BUBBLE_WORD;
          ins_valid <= 1'b0;
          state     <= S_RESOLVE;
        end
        S_RESOLVE: begin
          // PCnew is the decoder's registered result for the word just executed.
          PC    <= (PCnew != '0) ? PCnew : PC + 32'd1;
          state <= S_FETCH;
        end
        S_HALT: begin
          ins       <= BUBBLE_WORD;
          ins_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_ICOUNT_EN
  logic [31:0] icount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      icount_q <= '0;
    end else if (issue) begin
      icount_q <= icount_q + 32'd1;
    end
  end

  assign icount = icount_q;
`else
  assign icount = '0;
`endif

endmodule
